// File: rtl/fpadd_accum_ctrl_if.sv
// fpadd_accum_ctrl_if
// Groups the three handshakes around the accumulation controller:
//   input stream  : in_valid, in_ready, in_data[31:0], in_last
//   adder link    : add_start, add_a[31:0], add_b[31:0], add_sum[31:0], add_done
//   output result : out_valid, out_ready, out_data[31:0], out_count[15:0], out_err
// The master modport is the controller's view. The slave modport is the
// environment's view: the upstream source, the FP32 adder and the downstream sink.
interface fpadd_accum_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic        add_start;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic [31:0] add_sum;
    logic        add_done;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [15:0] out_count;
    logic        out_err;

    modport master (
        input  in_valid, in_data, in_last, add_sum, add_done, out_ready,
        output in_ready, add_start, add_a, add_b, out_valid, out_data,
               out_count, out_err
    );

    modport slave (
        output in_valid, in_data, in_last, add_sum, add_done, out_ready,
        input  in_ready, add_start, add_a, add_b, out_valid, out_data,
               out_count, out_err
    );
endinterface

// File: rtl/fpadd_accum_ctrl.sv
// fpadd_accum_ctrl
// Folds a burst of FP32 words into a running sum using an external multi-cycle
// adder (start/done handshake). It then presents the total, the beat count and
// an abort flag on a valid/ready output.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : fpadd_accum_ctrl_if.master (input stream, adder link, result)
// Parameter TIMEOUT (2..255): maximum number of WAIT cycles before the add is abandoned.
//
// state | meaning
// EMPTY | idle, first beat of a burst seeds the accumulator (no add)
// READY | take next beat, latch adder operands
// ISSUE | add_start pulse
// GUARD | skip one cycle so a stale add_done from the previous op is not seen
// WAIT  | wait for add_done, bounded by TIMEOUT
// DRAIN | after an abort, swallow beats up to and including in_last
// DONE  | result held on the output until out_ready
module fpadd_accum_ctrl #(
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    fpadd_accum_ctrl_if.master     bus
);

    typedef enum logic [2:0] {
        EMPTY,
        READY,
        ISSUE,
        GUARD,
        WAIT,
        DONE,
        DRAIN
    } state_t;

    localparam logic [7:0] TIMER_END = 8'(TIMEOUT - 1);

    state_t      state;
    logic [31:0] acc;
    logic [15:0] count;
    logic        err;
    logic        last_r;
    logic [7:0]  timer;
    logic        in_ready_r;
    logic        add_start_r;
    logic [31:0] add_a_r;
    logic [31:0] add_b_r;
    logic        out_valid_r;

    logic        in_fire;
    logic [15:0] count_inc;

    assign in_fire   = in_ready_r & bus.in_valid;
    assign count_inc = (count == 16'hFFFF) ? count : count + 16'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= EMPTY;
            acc         <= '0;
            count       <= '0;
            err         <= 1'b0;
            last_r      <= 1'b0;
            timer       <= '0;
            in_ready_r  <= 1'b0;
            add_start_r <= 1'b0;
            add_a_r     <= '0;
            add_b_r     <= '0;
            out_valid_r <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        acc   <= bus.in_data;
                        count <= 16'd1;
                        if (bus.in_last) begin
                            in_ready_r  <= 1'b0;
                            out_valid_r <= 1'b1;
                            state       <= DONE;
                        end else begin
                            state <= READY;
                        end
                    end else begin
                        // First cycle out of reset: open the input.
                        in_ready_r <= 1'b1;
                    end
                end
                READY: begin
                    if (in_fire) begin
                        add_a_r     <= acc;
                        add_b_r     <= bus.in_data;
                        last_r      <= bus.in_last;
                        count       <= count_inc;
                        in_ready_r  <= 1'b0;
                        add_start_r <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    add_start_r <= 1'b0;
                    state       <= GUARD;
                end
                GUARD: begin
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // done takes priority over the timer expiring on the same edge
                    if (bus.add_done) begin
                        acc <= bus.add_sum;
                        if (last_r) begin
                            out_valid_r <= 1'b1;
                            state       <= DONE;
                        end else begin
                            in_ready_r <= 1'b1;
                            state      <= READY;
                        end
                    end else if (timer == TIMER_END) begin
                        err <= 1'b1;
                        if (last_r) begin
                            out_valid_r <= 1'b1;
                            state       <= DONE;
                        end else begin
                            in_ready_r <= 1'b1;
                            state      <= DRAIN;
                        end
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                DRAIN: begin
                    if (in_fire && bus.in_last) begin
                        in_ready_r  <= 1'b0;
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (out_valid_r && bus.out_ready) begin
                        acc         <= '0;
                        count       <= '0;
                        err         <= 1'b0;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= EMPTY;
                    end
                end
                default: begin
                    state <= EMPTY;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.add_start = add_start_r;
    assign bus.add_a     = add_a_r;
    assign bus.add_b     = add_b_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = acc;
    assign bus.out_count = count;
    assign bus.out_err   = err;

endmodule

// File: tb/tb_fpadd_accum_ctrl.sv
module tb_fpadd_accum_ctrl;

    localparam int TMO = 16;

    logic clk;
    logic reset;
    fpadd_accum_ctrl_if bus();

    fpadd_accum_ctrl #(.TIMEOUT(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // FP32 <-> real for normal numbers and zero (all stimulus is small integers).
    function automatic logic [31:0] real_to_fp32(real r);
        logic [63:0] d;
        logic [10:0] e;
        if (r == 0.0) return 32'h0;
        d = $realtobits(r);
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic real fp32_to_real(logic [31:0] x);
        logic [63:0] d;
        logic [10:0] e;
        if (x[30:0] == 31'h0) return 0.0;
        e = {3'b000, x[30:23]} + 11'd896;
        d = {x[31], e, x[22:0], 29'h0};
        return $bitstoreal(d);
    endfunction

    // Adder model. mode 0: done cleared on start, set after adder_lat cycles.
    // mode 1: stale done held one extra cycle after start. mode 2: never completes.
    int          adder_lat  = 6;
    int          adder_mode = 0;
    bit          adder_rst  = 1'b1;
    int          adder_cnt  = 0;
    bit          clr_next   = 1'b0;
    logic [31:0] pend_sum;

    always @(posedge clk) begin
        if (adder_rst) begin
            bus.add_done <= 1'b0;
            bus.add_sum  <= 32'h0;
            adder_cnt    = 0;
            clr_next     = 1'b0;
        end else if (bus.add_start) begin
            pend_sum  = real_to_fp32(fp32_to_real(bus.add_a) + fp32_to_real(bus.add_b));
            adder_cnt = adder_lat;
            if (adder_mode == 1) clr_next = 1'b1;
            else bus.add_done <= 1'b0;
        end else begin
            if (clr_next) begin
                bus.add_done <= 1'b0;
                clr_next     = 1'b0;
            end
            if (adder_cnt > 0) begin
                adder_cnt--;
                if (adder_cnt == 0 && adder_mode != 2) begin
                    bus.add_done <= 1'b1;
                    bus.add_sum  <= pend_sum;
                end
            end
        end
    end

    // Start-pulse monitor.
    int          starts = 0;
    logic [31:0] last_a = 32'h0;
    logic [31:0] last_b = 32'h0;

    always @(negedge clk) begin
        if (bus.add_start === 1'b1) begin
            starts++;
            last_a = bus.add_a;
            last_b = bus.add_b;
        end
    end

    // Drivers: both start and end on a falling edge.
    task automatic send_beat(input logic [31:0] data, input logic last, output int waits);
        bus.in_valid = 1'b1;
        bus.in_data  = data;
        bus.in_last  = last;
        waits = 0;
        while (bus.in_ready !== 1'b1 && waits < 200) begin
            @(negedge clk);
            waits++;
        end
        if (bus.in_ready !== 1'b1) begin
            $display("FAIL beat_accept_timeout in_ready=%b required=1", bus.in_ready);
            bad++;
            total++;
            bus.in_valid = 1'b0;
        end else begin
            @(posedge clk);
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic get_result(input int hold, output logic [31:0] d,
                              output logic [15:0] c, output logic e);
        int waits;
        waits = 0;
        while (bus.out_valid !== 1'b1 && waits < 200) begin
            @(negedge clk);
            waits++;
        end
        if (bus.out_valid !== 1'b1) begin
            $display("FAIL result_timeout out_valid=%b required=1", bus.out_valid);
            bad++;
            total++;
            d = 32'hx;
            c = 16'hx;
            e = 1'bx;
        end else begin
            repeat (hold) @(negedge clk);
            d = bus.out_data;
            c = bus.out_count;
            e = bus.out_err;
            bus.out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        adder_rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data = 32'h0;
        bus.in_last = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        if ({bus.in_ready, bus.add_start, bus.out_valid, bus.out_err} !== 4'b0000) begin
            $display("FAIL reset_flags got=%b required=0000",
                     {bus.in_ready, bus.add_start, bus.out_valid, bus.out_err});
            bad++;
        end
        total++;
        if ({bus.add_a, bus.add_b, bus.out_data, bus.out_count} !== 112'h0) begin
            $display("FAIL reset_data a=%h b=%h data=%h count=%h required=0",
                     bus.add_a, bus.add_b, bus.out_data, bus.out_count);
            bad++;
        end
        total++;
        reset = 1'b0;
        adder_rst = 1'b0;
        @(negedge clk);
        if (bus.in_ready !== 1'b1) begin
            $display("FAIL reset_ready_after got=%b required=1", bus.in_ready);
            bad++;
        end
        total++;
    endtask

    task automatic test_basic;
        int w;
        int s0;
        logic [31:0] d;
        logic [15:0] c;
        logic e;
        adder_mode = 0;
        adder_lat = 6;
        s0 = starts;
        send_beat(32'h3F800000, 1'b0, w);
        send_beat(32'h40000000, 1'b0, w);
        send_beat(32'h40400000, 1'b1, w);
        get_result(0, d, c, e);
        if (d !== 32'h40C00000) begin
            $display("FAIL basic_data got=%h required=40c00000", d); bad++;
        end
        total++;
        if (c !== 16'd3) begin $display("FAIL basic_count got=%0d required=3", c); bad++; end
        total++;
        if (e !== 1'b0) begin $display("FAIL basic_err got=%b required=0", e); bad++; end
        total++;
        if (starts - s0 != 2) begin
            $display("FAIL basic_starts got=%0d required=2", starts - s0); bad++;
        end
        total++;
        if (last_a !== 32'h40400000 || last_b !== 32'h40400000) begin
            $display("FAIL basic_operands a=%h b=%h required=40400000/40400000", last_a, last_b);
            bad++;
        end
        total++;
    endtask

    task automatic test_single;
        int w;
        int s0;
        logic [31:0] d;
        logic [15:0] c;
        logic e;
        s0 = starts;
        send_beat(32'h3F800000, 1'b1, w);
        if (bus.out_valid !== 1'b1) begin
            $display("FAIL single_done_latency out_valid=%b required=1", bus.out_valid); bad++;
        end
        total++;
        if (bus.in_ready !== 1'b0) begin
            $display("FAIL single_ready_in_done got=%b required=0", bus.in_ready); bad++;
        end
        total++;
        get_result(0, d, c, e);
        if (d !== 32'h3F800000 || c !== 16'd1 || e !== 1'b0) begin
            $display("FAIL single_result data=%h count=%0d err=%b required=3f800000/1/0", d, c, e);
            bad++;
        end
        total++;
        if (starts != s0) begin
            $display("FAIL single_starts got=%0d required=0", starts - s0); bad++;
        end
        total++;
    endtask

    task automatic test_stale_done;
        int w;
        logic [31:0] d;
        logic [15:0] c;
        logic e;
        adder_mode = 1;
        adder_lat = 4;
        send_beat(32'h3F800000, 1'b0, w);
        send_beat(32'h40000000, 1'b0, w);
        send_beat(32'h40400000, 1'b1, w);
        get_result(0, d, c, e);
        if (d !== 32'h40C00000 || c !== 16'd3 || e !== 1'b0) begin
            $display("FAIL stale_result data=%h count=%0d err=%b required=40c00000/3/0", d, c, e);
            bad++;
        end
        total++;
        adder_mode = 0;
    endtask

    task automatic test_timeout;
        int w;
        int s0;
        logic [31:0] d;
        logic [15:0] c;
        logic e;
        adder_mode = 2;
        s0 = starts;
        send_beat(32'h3F800000, 1'b0, w);
        send_beat(32'h40000000, 1'b0, w);
        send_beat(32'h40400000, 1'b1, w);
        // ISSUE + GUARD + TMO cycles of WAIT before DRAIN opens the input
        if (w != TMO + 2) begin
            $display("FAIL timeout_abort_cycles got=%0d required=%0d", w, TMO + 2); bad++;
        end
        total++;
        get_result(0, d, c, e);
        if (d !== 32'h3F800000 || c !== 16'd2 || e !== 1'b1) begin
            $display("FAIL timeout_result data=%h count=%0d err=%b required=3f800000/2/1", d, c, e);
            bad++;
        end
        total++;
        if (starts - s0 != 1) begin
            $display("FAIL timeout_starts got=%0d required=1", starts - s0); bad++;
        end
        total++;
        adder_mode = 0;
    endtask

    task automatic test_backpressure;
        int w;
        int v0;
        int v1;
        int waits;
        logic [31:0] exp_d;
        logic [31:0] d;
        logic [15:0] c;
        logic e;
        adder_lat = 6;
        v0 = $urandom_range(1, 64);
        v1 = $urandom_range(1, 64);
        exp_d = real_to_fp32(real'(v0 + v1));
        send_beat(real_to_fp32(real'(v0)), 1'b0, w);
        send_beat(real_to_fp32(real'(v1)), 1'b1, w);
        waits = 0;
        while (bus.out_valid !== 1'b1 && waits < 200) begin
            @(negedge clk);
            waits++;
        end
        for (int i = 0; i < 10; i++) begin
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
                $display("FAIL bp_flags cycle=%0d valid=%b ready=%b required=1/0",
                         i, bus.out_valid, bus.in_ready);
                bad++;
            end
            total++;
            if (bus.out_data !== exp_d || bus.out_count !== 16'd2) begin
                $display("FAIL bp_hold cycle=%0d data=%h count=%0d required=%h/2",
                         i, bus.out_data, bus.out_count, exp_d);
                bad++;
            end
            total++;
            @(negedge clk);
        end
        get_result(0, d, c, e);
        if (d !== exp_d) begin
            $display("FAIL bp_data got=%h required=%h", d, exp_d); bad++;
        end
        total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_count !== 16'd0) begin
            $display("FAIL bp_back_to_empty ready=%b valid=%b count=%0d required=1/0/0",
                     bus.in_ready, bus.out_valid, bus.out_count);
            bad++;
        end
        total++;
    endtask

    task automatic test_reset_in_wait;
        int w;
        int s0;
        logic [31:0] d;
        logic [15:0] c;
        logic e;
        adder_lat = 6;
        s0 = starts;
        send_beat(32'h3F800000, 1'b0, w);
        send_beat(32'h40000000, 1'b0, w);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        if ({bus.in_ready, bus.add_start, bus.out_valid, bus.out_err} !== 4'b0000 ||
            {bus.add_a, bus.add_b, bus.out_data, bus.out_count} !== 112'h0) begin
            $display("FAIL rst_wait_outputs ready=%b start=%b valid=%b a=%h b=%h data=%h count=%h required=0",
                     bus.in_ready, bus.add_start, bus.out_valid, bus.add_a, bus.add_b,
                     bus.out_data, bus.out_count);
            bad++;
        end
        total++;
        repeat (10) @(negedge clk);
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || starts - s0 != 1) begin
            $display("FAIL rst_wait_late_done valid=%b ready=%b starts=%0d required=0/1/1",
                     bus.out_valid, bus.in_ready, starts - s0);
            bad++;
        end
        total++;
        send_beat(32'h40000000, 1'b1, w);
        get_result(0, d, c, e);
        if (d !== 32'h40000000 || c !== 16'd1 || e !== 1'b0) begin
            $display("FAIL rst_wait_fresh data=%h count=%0d err=%b required=40000000/1/0", d, c, e);
            bad++;
        end
        total++;
    endtask

    task automatic test_random_bursts;
        int w;
        int len;
        int sum_i;
        int v;
        int s0;
        logic [31:0] d;
        logic [15:0] c;
        logic e;
        adder_mode = 0;
        for (int b = 0; b < 8; b++) begin
            len = $urandom_range(1, 6);
            sum_i = 0;
            s0 = starts;
            adder_lat = $urandom_range(1, 10);
            for (int k = 0; k < len; k++) begin
                v = $urandom_range(1, 64);
                sum_i += v;
                repeat ($urandom_range(0, 2)) @(negedge clk);
                send_beat(real_to_fp32(real'(v)), (k == len - 1), w);
            end
            get_result($urandom_range(0, 3), d, c, e);
            if (d !== real_to_fp32(real'(sum_i))) begin
                $display("FAIL rand_data burst=%0d got=%h required=%h", b, d, real_to_fp32(real'(sum_i)));
                bad++;
            end
            total++;
            if (c !== 16'(len) || e !== 1'b0) begin
                $display("FAIL rand_count burst=%0d count=%0d err=%b required=%0d/0", b, c, e, len);
                bad++;
            end
            total++;
            if (starts - s0 != len - 1) begin
                $display("FAIL rand_starts burst=%0d got=%0d required=%0d", b, starts - s0, len - 1);
                bad++;
            end
            total++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single();
        test_stale_done();
        test_timeout();
        test_backpressure();
        test_reset_in_wait();
        test_random_bursts();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
